// File: rtl/regfile_pkg.sv
// Shared sizing and state encoding for the register-file write-port controller.
package regfile_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int CNTW = 2;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrlStateT;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register in-flight producer counters with hazard, full and idle lookups.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          incEn,
    input  logic [AW-1:0] incAddr,
    input  logic          decEn,
    input  logic [AW-1:0] decAddr,
    input  logic [AW-1:0] rsAddr,
    input  logic [AW-1:0] rtAddr,
    input  logic [AW-1:0] rdAddr,
    input  logic [AW-1:0] dbgAddr,
    input  logic [AW-1:0] wbAddr,
    output logic          hazard,
    output logic          rdFull,
    output logic          dbgIdle,
    output logic          wbIdle
);

    logic [NREG-1:0][CNTW-1:0] cntReg;
    logic [NREG-1:0][CNTW-1:0] cntNext;

    // Register 0 is hardwired and never has producers.
    assign cntNext[0] = '0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
            logic incHit;
            logic decHit;
            assign incHit = incEn && (incAddr == AW'(gi));
            // A stray writeback never drives a counter below zero.
            assign decHit = decEn && (decAddr == AW'(gi)) && (cntReg[gi] != '0);
            assign cntNext[gi] = (incHit && !decHit) ? cntReg[gi] + 1'b1 :
                                 (decHit && !incHit) ? cntReg[gi] - 1'b1 :
                                                       cntReg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            cntReg <= '0;
        end else begin
            cntReg <= cntNext;
        end
    end

    assign hazard  = ((rsAddr != '0) && (cntReg[rsAddr] != '0)) ||
                     ((rtAddr != '0) && (cntReg[rtAddr] != '0));
    assign rdFull  = (cntReg[rdAddr] == CNT_MAX);
    assign dbgIdle = (cntReg[dbgAddr] == '0);
    assign wbIdle  = (cntReg[wbAddr] == '0);

endmodule

// File: rtl/regfile_ctrl.sv
// Owns the register file write port: post-reset clear sweep, writeback/debug
// arbitration with registered write outputs, and RAW-hazard issue stalling.
module regfile_ctrl
    import regfile_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    input  logic          dbg_valid,
    output logic          dbg_ready,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_data,
    input  logic          iss_valid,
    output logic          iss_ready,
    input  logic [AW-1:0] iss_rd,
    input  logic [AW-1:0] iss_rs,
    input  logic [AW-1:0] iss_rt,
    output logic          stall,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          busy,
    output logic          sb_err
);

    ctrlStateT     stateReg, stateNext;
    logic [AW-1:0] sweepPtrReg, sweepPtrNext;
    logic          rfWeReg, rfWeNext;
    logic [AW-1:0] rfWaddrReg, rfWaddrNext;
    logic [DW-1:0] rfWdataReg, rfWdataNext;
    logic          wbDecReg, wbDecNext;
    logic          sbErrReg, sbErrNext;

    logic hazard, rdFull, dbgIdle, wbIdle;
    logic wbWrite, incEn;

    regfile_scoreboard u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .incEn   (incEn),
        .incAddr (iss_rd),
        .decEn   (wbDecReg),
        .decAddr (rfWaddrReg),
        .rsAddr  (iss_rs),
        .rtAddr  (iss_rt),
        .rdAddr  (iss_rd),
        .dbgAddr (dbg_addr),
        .wbAddr  (wb_rd),
        .hazard  (hazard),
        .rdFull  (rdFull),
        .dbgIdle (dbgIdle),
        .wbIdle  (wbIdle)
    );

    assign busy      = (stateReg == INIT);
    assign wbWrite   = wb_valid && (wb_rd != '0);
    // Debug only gets the port when writeback leaves it free and nothing is in flight to that register.
    assign dbg_ready = (stateReg == RUN) && !wbWrite && dbg_valid && dbgIdle;
    assign stall     = busy || (iss_valid && (hazard || rdFull));
    assign iss_ready = iss_valid && !stall;
    assign incEn     = iss_ready && (iss_rd != '0);

    always_comb begin
        stateNext    = stateReg;
        sweepPtrNext = sweepPtrReg;
        rfWeNext     = 1'b0;
        rfWaddrNext  = rfWaddrReg;
        rfWdataNext  = rfWdataReg;
        wbDecNext    = 1'b0;
        sbErrNext    = sbErrReg;
        case (stateReg)
            INIT: begin
                rfWeNext     = 1'b1;
                rfWaddrNext  = sweepPtrReg;
                rfWdataNext  = '0;
                sweepPtrNext = sweepPtrReg + 1'b1;
                if (sweepPtrReg == AW'(NREG - 1)) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (wbWrite) begin
                    rfWeNext    = 1'b1;
                    rfWaddrNext = wb_rd;
                    rfWdataNext = wb_data;
                    wbDecNext   = 1'b1;
                    if (wbIdle) begin
                        sbErrNext = 1'b1;
                    end
                end else if (dbg_ready && (dbg_addr != '0)) begin
                    rfWeNext    = 1'b1;
                    rfWaddrNext = dbg_addr;
                    rfWdataNext = dbg_data;
                end
            end
            default: stateNext = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg    <= INIT;
            sweepPtrReg <= '0;
            rfWeReg     <= 1'b0;
            rfWaddrReg  <= '0;
            rfWdataReg  <= '0;
            wbDecReg    <= 1'b0;
            sbErrReg    <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            sweepPtrReg <= sweepPtrNext;
            rfWeReg     <= rfWeNext;
            rfWaddrReg  <= rfWaddrNext;
            rfWdataReg  <= rfWdataNext;
            wbDecReg    <= wbDecNext;
            sbErrReg    <= sbErrNext;
        end
    end

    assign rf_we    = rfWeReg;
    assign rf_waddr = rfWaddrReg;
    assign rf_wdata = rfWdataReg;
    assign sb_err   = sbErrReg;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl; register-file writes are checked in order against a queue.
module tb_regfile_ctrl;
    import regfile_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wb_valid, dbg_valid, iss_valid;
    logic [AW-1:0] wb_rd, dbg_addr, iss_rd, iss_rs, iss_rt;
    logic [DW-1:0] wb_data, dbg_data;
    logic          dbg_ready, iss_ready, stall, rf_we, busy, sb_err;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wrT;

    wrT expQ[$];
    int nCompared   = 0;
    int nMismatched = 0;

    regfile_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .dbg_valid (dbg_valid),
        .dbg_ready (dbg_ready),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_rd    (iss_rd),
        .iss_rs    (iss_rs),
        .iss_rt    (iss_rt),
        .stall     (stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy      (busy),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        dbg_valid = 1'b0; dbg_addr = '0; dbg_data = '0;
        iss_valid = 1'b0; iss_rd = '0; iss_rs = '0; iss_rt = '0;
    endtask

    task automatic pushInit();
        for (int i = 0; i < NREG; i++) begin
            expQ.push_back('{addr: AW'(i), data: '0});
        end
    endtask

    task automatic pushWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        expQ.push_back('{addr: a, data: d});
    endtask

    // Every committed register-file write must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && rf_we) begin
            wrT e;
            $display("rf write addr=%0d data=0x%0h", rf_waddr, rf_wdata);
            nCompared++;
            assert (expQ.size() != 0) else begin
                nMismatched++;
                $error("FAIL rf_unexpected: observed write addr %0d, expected no write", rf_waddr);
            end
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                chk("rf_waddr", DW'(rf_waddr), DW'(e.addr));
                chk("rf_wdata", rf_wdata, e.data);
            end
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        tick(); tick();
        settle();
        chk("rst_rf_we", DW'(rf_we), 0);
        chk("rst_rf_waddr", DW'(rf_waddr), 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_busy", DW'(busy), 1);
        chk("rst_iss_ready", DW'(iss_ready), 0);
        chk("rst_dbg_ready", DW'(dbg_ready), 0);
        chk("rst_stall", DW'(stall), 1);
        chk("rst_sb_err", DW'(sb_err), 0);
        tick();

        // Init sweep: 32 busy cycles, writes 0..31 with zero data.
        reset = 1'b0;
        pushInit();
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234;
        for (int k = 0; k < NREG; k++) begin
            settle();
            chk("init_busy", DW'(busy), 1);
            if (k == 0) chk("init_stall", DW'(stall), 1);
            tick();
        end
        idle();
        settle();
        chk("run_busy", DW'(busy), 0);
        chk("run_stall_idle", DW'(stall), 0);
        repeat (8) tick();
        chk("init_drained", DW'(expQ.size()), 0);

        // RAW hazard on r8 and release after writeback commits.
        iss_valid = 1'b1; iss_rd = 5'd8; iss_rs = 5'd1; iss_rt = 5'd2;
        settle(); chk("A_issue_ready", DW'(iss_ready), 1); tick();
        iss_rd = 5'd0; iss_rs = 5'd8; iss_rt = 5'd0;
        settle(); chk("A_raw_stall", DW'(stall), 1); chk("A_raw_not_ready", DW'(iss_ready), 0); tick();
        wb_valid = 1'b1; wb_rd = 5'd8; wb_data = 32'h5; pushWrite(5'd8, 32'h5);
        settle(); chk("A_wb_cycle_stall", DW'(stall), 1); tick();
        wb_valid = 1'b0;
        settle(); chk("A_rf_we", DW'(rf_we), 1); chk("A_commit_stall", DW'(stall), 1); tick();
        settle(); chk("A_stall_drop", DW'(stall), 0); chk("A_ready_after", DW'(iss_ready), 1); tick();
        idle();

        // Writeback beats debug; debug goes next cycle.
        iss_valid = 1'b1; iss_rd = 5'd9;
        settle(); chk("B_issue9", DW'(iss_ready), 1); tick();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h900;
        dbg_valid = 1'b1; dbg_addr = 5'd10; dbg_data = 32'hA00;
        pushWrite(5'd9, 32'h900); pushWrite(5'd10, 32'hA00);
        settle(); chk("B_dbg_blocked", DW'(dbg_ready), 0); tick();
        wb_valid = 1'b0;
        settle(); chk("B_dbg_ready", DW'(dbg_ready), 1); chk("B_first_addr", DW'(rf_waddr), 9); tick();
        dbg_valid = 1'b0;
        settle(); chk("B_second_addr", DW'(rf_waddr), 10); chk("B_sb_err", DW'(sb_err), 0); tick();

        // Counter saturation on r12.
        for (int i = 0; i < 3; i++) begin
            iss_valid = 1'b1; iss_rd = 5'd12;
            settle(); chk("C_issue12", DW'(iss_ready), 1); tick();
        end
        settle(); chk("C_full_stall", DW'(stall), 1); chk("C_full_not_ready", DW'(iss_ready), 0); tick();
        wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'hC; pushWrite(5'd12, 32'hC);
        settle(); chk("C_wb_stall", DW'(stall), 1); tick();
        wb_valid = 1'b0;
        settle(); chk("C_commit_stall", DW'(stall), 1); tick();
        settle(); chk("C_issue_after_wb", DW'(iss_ready), 1); tick();
        idle();

        // Writeback to r0 is suppressed; writeback to idle r13 flags sb_err.
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
        settle(); tick();
        wb_valid = 1'b0;
        settle(); chk("D_rd0_suppressed", DW'(rf_we), 0); chk("D_rd0_no_err", DW'(sb_err), 0); tick();
        wb_valid = 1'b1; wb_rd = 5'd13; wb_data = 32'hD; pushWrite(5'd13, 32'hD);
        settle(); chk("D_err_not_yet", DW'(sb_err), 0); tick();
        wb_valid = 1'b0;
        settle(); chk("D_sb_err_set", DW'(sb_err), 1); chk("D_write13", DW'(rf_we), 1); tick();
        repeat (5) tick();
        iss_valid = 1'b1; iss_rs = 5'd13;
        settle(); chk("D_sb_err_sticky", DW'(sb_err), 1); chk("D_no_underflow", DW'(stall), 0); tick();
        idle();

        // Reset mid-RUN, then again at cycle 10 of INIT.
        reset = 1'b1; expQ.delete();
        tick();
        settle(); chk("E_sb_err_cleared", DW'(sb_err), 0); chk("E_busy", DW'(busy), 1); tick();
        reset = 1'b0;
        pushInit();
        repeat (10) tick();
        reset = 1'b1; expQ.delete();
        tick();
        settle(); chk("E_reset_discard", DW'(rf_we), 0); tick();
        reset = 1'b0;
        pushInit();
        settle(); chk("E_restart_busy", DW'(busy), 1); tick();
        settle(); chk("E_first_addr", DW'(rf_waddr), 0); chk("E_first_we", DW'(rf_we), 1);
        repeat (40) tick();
        chk("E_sweep_complete", DW'(expQ.size()), 0);
        iss_valid = 1'b1; iss_rd = 5'd12;
        settle(); chk("E_counters_cleared", DW'(iss_ready), 1); tick();
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Write-port controller and scoreboard for the 32×32 pipeline register file. It owns the file's single write port, clears all registers after reset, and arbitrates writeback against a debug/loader port. It also tracks in-flight destination registers so decode can stall on RAW hazards. It sits between decode/writeback and the register file; the register file itself is unchanged.

## Interface
- NREG, 32, number of architectural registers
- AW, 5, register address width
- DW, 32, data width
- CNTW, 2, per-register in-flight counter width (max 2^CNTW−1 producers)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- wb_valid  in  1  writeback result present this cycle (always accepted in RUN)
- wb_rd  in  AW  writeback destination
- wb_data  in  DW  writeback value
- dbg_valid  in  1  debug write request
- dbg_ready  out  1  debug write accepted this cycle
- dbg_addr  in  AW  debug destination
- dbg_data  in  DW  debug value
- iss_valid  in  1  decode wants to issue
- iss_ready  out  1  issue accepted this cycle
- iss_rd, iss_rs, iss_rt  in  AW each  destination and sources of issuing instruction
- stall  out  1  decode must hold
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- busy  out  1  init sweep in progress
- sb_err  out  1  sticky: writeback to register with zero in-flight count

## Operation
- States: INIT, RUN. reset → INIT, sweep pointer 0, all counters 0, sb_err 0.
- INIT: one write per cycle, addr = pointer, data 0, pointer 0..31; after writing 31 → RUN. busy=1, iss_ready=0, dbg_ready=0, stall=1. wb_valid in INIT ignored.
- RUN write arbitration, wb strictly first: wb_valid & wb_rd≠0 → write wb. Otherwise dbg_ready = dbg_valid & cnt[dbg_addr]=0 → write dbg. Any write to address 0 suppressed (rf_we stays 0); a dbg write to 0 still handshakes.
- Scoreboard: cnt[r] per register, r≠0. Issue accepted with iss_rd≠0 → cnt[iss_rd]+1. A cycle with rf_we=1 from wb → cnt[rf_waddr]−1. Both on same register in same cycle → unchanged.
- Hazard: haz = (iss_rs≠0 & cnt[iss_rs]≠0) | (iss_rt≠0 & cnt[iss_rt]≠0). stall = busy | (iss_valid & (haz | cnt[iss_rd]=max)). iss_ready = iss_valid & ~stall.
- wb_valid with wb_rd≠0 and cnt[wb_rd]=0 → sb_err set (sticky until reset); write still performed, counter not decremented below 0.
- Counters never overflow: a full counter blocks issue via stall.

## Timing
- Reset values: rf_we 0, rf_waddr 0, rf_wdata 0, busy 1, iss_ready 0, dbg_ready 0, stall 1, sb_err 0.
- rf_we/rf_waddr/rf_wdata registered: write visible one cycle after wb_valid/dbg handshake cycle.
- Counter decrement occurs on the edge ending the rf_we=1 cycle, so stall on that register drops the cycle after the register file commits. Decrement is never earlier.
- stall, iss_ready, dbg_ready are combinational from current counters and inputs.
- INIT lasts exactly 32 cycles after reset deasserts; first RUN cycle is cycle 33.
- reset asserted mid-RUN or mid-INIT: next cycle is INIT from pointer 0. All counters and pending rf writes are discarded.

## Structure
- Package regfile_pkg: NREG, AW, DW, CNTW, state enum {INIT, RUN}.
- Sub-module regfile_scoreboard: counter array, inc/dec ports, two hazard lookups, full flag. The top holds FSM, sweep, arbitration, output registers.

## Test plan
- Reset, then run 40 cycles → rf_we=1 for cycles 1–32 with addr 0..31, data 0; busy falls after 32; stall=0 with iss_valid=0.
- Issue rd=8, then issue rs=8 next cycle → stall=1. wb_valid rd=8 data 0x5 → rf_we next cycle (addr 8, data 0x5); stall drops the cycle after.
- Same cycle: wb_valid rd=9 and dbg_valid addr 10 → wb written first; dbg_ready=1 the following cycle; rf writes 9 then 10.
- Issue rd=12 three times with no writeback → fourth issue rd=12 stalls (cnt=3); one wb to 12 → issue accepted.
- wb_valid rd=0 data 0xFFFF → rf_we stays 0, no counter change; wb_valid rd=13 with cnt 0 → sb_err=1 and persists until reset.
- Assert reset at cycle 10 of INIT → sweep restarts at address 0; 32 full writes follow reset deassertion.
